mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-access unit for the 32I pipeline. It sits directly downstream of the EX/MEM pipeline register. It consumes that register's memory controls, ALU address and rs2 store data, runs a request/grant/response handshake with data memory, and returns aligned, extended load data to the MEM/WB register. While an access is in flight it holds the pipeline with `stall`.

## Interface
- No parameters. XLEN is fixed at 32.
- `clk`  in  1  pipeline clock.
- `reset`  in  1  asynchronous, active-low reset.
- `mem_read`  in  1  load request from EX/MEM.
- `mem_write`  in  1  store request from EX/MEM.
- `mem_size`  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
- `sign`  in  1  load extension: 1 sign-extend (LB/LH), 0 zero-extend (LBU/LHU).
- `addr`  in  32  byte address (EX/MEM `alu`).
- `store_data`  in  32  store operand (EX/MEM `rs2`).
- `dmem_req`  out  1  bus request, registered.
- `dmem_we`  out  1  1 store, 0 load.
- `dmem_addr`  out  32  word address, `{addr[31:2],2'b00}`.
- `dmem_be`  out  4  byte enables.
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_gnt`  in  1  request accepted.
- `dmem_rvalid`  in  1  read data valid.
- `dmem_rdata`  in  32  read word.
- `load_data`  out  32  aligned, extended load result.
- `stall`  out  1  holds the EX/MEM register and all earlier stages.
- `misalign`  out  1  one-cycle misaligned-access flag.

## Operation
- An access is `mem_read | mem_write`. If both are set, the access is a store and the read is ignored.
- Misaligned cases:
  - Half access with `addr[0]=1`.
  - Word (or size 11) access with `addr[1:0]!=0`.
  - Response: no bus activity, `misalign=1` combinationally in that cycle, `stall=0`, `load_data` unchanged.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - On an aligned access, latch `dmem_addr`, `dmem_we`, `dmem_be`, `dmem_wdata`, `sign`, `addr[1:0]` and `mem_size`, then go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - `dmem_req=1`, with all bus outputs stable.
  - On `dmem_gnt`: a store goes to DONE, a load goes to RESP.
  - Without `dmem_gnt`: stay in REQ indefinitely.
- RESP:
  - `dmem_req=0`.
  - On `dmem_rvalid`: capture the extracted and extended data into `load_data`, go to DONE.
- DONE: `stall=0` and the instruction advances. Go to IDLE unconditionally; no new access is sampled in this cycle.
- `stall` is combinational: `(IDLE & aligned access) | REQ | RESP`.
- Byte enables:
  - Byte: `4'b0001 << addr[1:0]`.
  - Half: `4'b0011 << addr[1:0]`.
  - Word: `4'b1111`.
- Write data:
  - Byte: `store_data[7:0]` replicated x4.
  - Half: `store_data[15:0]` replicated x2.
  - Word: as-is.
- Load extraction: `dmem_rdata >> (8*addr[1:0])`, then take the low 8/16/32 bits and extend per the latched `sign`. Word loads ignore `sign`.
- `load_data` holds its value until the next load completes. Stores and misaligned accesses do not modify it.
- `dmem_rvalid` is ignored outside RESP. `dmem_gnt` is ignored outside REQ.

## Timing
- Reset (asynchronous, immediate): state IDLE; `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_be`, `dmem_wdata` and `load_data` all 0.
  - `stall` and `misalign` are combinational. With reset low, the FSM is held in IDLE, so they depend only on the current access inputs.
  - Reset mid-transaction drops `dmem_req` at once and discards any pending response.
- `dmem_req` first rises in the cycle after the access is seen in IDLE.
- Store, zero-wait grant: 3 cycles (IDLE, REQ, DONE), of which 2 are stalled.
- Load, grant plus rvalid next cycle: 4 cycles (IDLE, REQ, RESP, DONE), of which 3 are stalled.
- Each cycle of missing `dmem_gnt` or `dmem_rvalid` adds exactly one stall cycle.
- `load_data` is valid in DONE and stays valid while MEM/WB samples it at the end of DONE.
- Back-to-back accesses: the next instruction is seen in IDLE on the cycle after DONE, with no lost cycles beyond the DONE→IDLE transition.

## Test plan
- LB: addr=0x1003, rdata=0x80FF_0000, `sign=1`, gnt and rvalid immediate → `dmem_be=1000`, `load_data=0xFFFF_FF80`, `stall` high for exactly 3 cycles.
- LHU: addr=0x2002, rdata=0xBEEF_1234, `sign=0` → `dmem_be=1100`, `load_data=0x0000_BEEF`.
- SB: addr=0x11, `store_data=0x0000_00A5`, gnt delayed 2 cycles → `dmem_we=1`, `dmem_addr=0x10`, `dmem_be=0010`, `dmem_wdata=0xA5A5_A5A5`, `stall` high for 4 cycles, `load_data` unchanged.
- LW at addr=0x6 → `misalign=1` for one cycle, `stall=0`, `dmem_req` never rises.
- `mem_read` and `mem_write` both set, word at 0x40, `store_data=0xDEADBEEF` → store issued with `dmem_wdata=0xDEADBEEF`, no RESP state entered.
- Reset asserted during RESP of a LW → `dmem_req` and `load_data` are 0 immediately. A later `dmem_rvalid` is ignored, and the next LW completes normally.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory-access stage: request/grant/response handshake with data memory,
// store lane formatting and load alignment/extension for the 32I pipeline.
module mem_access_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        sign,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        misalign
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t            state_q, state_d;
  logic              access_c, misalign_c, start_c, load_en_c;
  logic [3:0]        be_c;
  logic [XLEN-1:0]   wdata_c, shifted_c, ext_c;
  logic              sign_q;
  logic [1:0]        off_q, size_q;

  // Access decode, alignment check and handshake-independent stall terms
  always_comb begin
    access_c   = mem_read | mem_write;
    misalign_c = access_c &
                 (((mem_size == 2'b01) & addr[0]) |
                  (mem_size[1] & (addr[1:0] != 2'b00)));
    start_c    = (state_q == IDLE) & access_c & ~misalign_c;
    misalign   = (state_q == IDLE) & misalign_c;
    stall      = start_c | (state_q == REQ) | (state_q == RESP);
  end

  // Byte enables and lane-replicated store data
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = store_data;
    case (mem_size)
      2'b00: begin
        be_c    = 4'b0001 << addr[1:0];
        wdata_c = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_c    = 4'b0011 << addr[1:0];
        wdata_c = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Load alignment and extension using the latched access attributes
  always_comb begin
    shifted_c = dmem_rdata >> {off_q, 3'b000};
    ext_c     = shifted_c;
    case (size_q)
      2'b00:   ext_c = {{24{sign_q & shifted_c[7]}}, shifted_c[7:0]};
      2'b01:   ext_c = {{16{sign_q & shifted_c[15]}}, shifted_c[15:0]};
      default: ;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    load_en_c = 1'b0;
    case (state_q)
      IDLE: if (start_c) state_d = REQ;
      REQ:  if (dmem_gnt) state_d = dmem_we ? DONE : RESP;
      RESP: if (dmem_rvalid) begin
        load_en_c = 1'b1;
        state_d   = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Bus outputs and latched access attributes; request tracks the REQ state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      load_data  <= '0;
      sign_q     <= 1'b0;
      off_q      <= 2'b00;
      size_q     <= 2'b00;
    end else begin
      dmem_req <= (state_d == REQ);
      if (start_c) begin
        dmem_we    <= mem_write;
        dmem_addr  <= {addr[31:2], 2'b00};
        dmem_be    <= be_c;
        dmem_wdata <= wdata_c;
        sign_q     <= sign;
        off_q      <= addr[1:0];
        size_q     <= mem_size;
      end
      if (load_en_c) load_data <= ext_c;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage with a simple
// grant/rvalid responder driven by per-access delay settings.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write, sign;
  logic [1:0]  mem_size;
  logic [31:0] addr, store_data;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, load_data;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid, stall, misalign;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_stage dut (
    .clk(clk), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .sign(sign), .addr(addr), .store_data(store_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .load_data(load_data), .stall(stall), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    mem_read = 1'b0; mem_write = 1'b0; mem_size = 2'b00; sign = 1'b0;
    addr = '0; store_data = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
  endtask

  // Present one access and respond; returns stall count and bus values seen at grant
  task automatic do_access(input logic rd, input logic wr, input logic [1:0] sz,
                           input logic sg, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rdat, input int gd, input int rvd,
                           output int stalls, output logic mis0, output logic req_seen,
                           output logic [31:0] g_addr, output logic [31:0] g_wdata,
                           output logic [3:0] g_be, output logic g_we);
    int rc, vc;
    logic granted, done;
    stalls = 0; rc = 0; vc = 0; granted = 1'b0; done = 1'b0;
    mis0 = 1'b0; req_seen = 1'b0; g_addr = '0; g_wdata = '0; g_be = '0; g_we = 1'b0;
    @(negedge clk);
    mem_read = rd; mem_write = wr; mem_size = sz; sign = sg;
    addr = a; store_data = wd; dmem_rdata = rdat;
    for (int c = 0; c < 64 && !done; c++) begin
      if (c > 0) @(negedge clk);
      dmem_gnt    = dmem_req && (rc == gd);
      dmem_rvalid = granted && !dmem_req && (vc == rvd);
      #1;
      if (dmem_req) begin
        req_seen = 1'b1;
        if (dmem_gnt) begin
          g_addr = dmem_addr; g_wdata = dmem_wdata; g_be = dmem_be; g_we = dmem_we;
          granted = !wr;
        end
        rc++;
      end else if (granted) begin
        vc++;
      end
      if (c == 0) mis0 = misalign;
      if (stall) stalls++;
      else done = 1'b1;
    end
    if (!done) check("access_timeout", 32'd0, 32'd1);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
  endtask

  int          st;
  logic        m0, rq, we;
  logic [31:0] ga, gw;
  logic [3:0]  gb;

  initial begin
    clear_inputs();
    dmem_rdata = '0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", {31'd0, dmem_req}, 32'd0);
    check("rst_we", {31'd0, dmem_we}, 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_be", {28'd0, dmem_be}, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_load", load_data, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    reset = 1'b1;

    // LB 0x1003, sign-extended top byte
    do_access(1, 0, 2'b00, 1, 32'h1003, 32'h0, 32'h80FF_0000, 0, 0, st, m0, rq, ga, gw, gb, we);
    check("lb_be", {28'd0, gb}, 32'h8);
    check("lb_addr", ga, 32'h1000);
    check("lb_we", {31'd0, we}, 32'd0);
    check("lb_load", load_data, 32'hFFFF_FF80);
    check("lb_stalls", 32'(st), 32'd3);

    // LHU 0x2002, zero-extended upper half
    do_access(1, 0, 2'b01, 0, 32'h2002, 32'h0, 32'hBEEF_1234, 0, 0, st, m0, rq, ga, gw, gb, we);
    check("lhu_be", {28'd0, gb}, 32'hC);
    check("lhu_load", load_data, 32'h0000_BEEF);
    check("lhu_stalls", 32'(st), 32'd3);

    // SB 0x11 with grant delayed two cycles
    do_access(0, 1, 2'b00, 0, 32'h11, 32'h0000_00A5, 32'h0, 2, 0, st, m0, rq, ga, gw, gb, we);
    check("sb_we", {31'd0, we}, 32'd1);
    check("sb_addr", ga, 32'h10);
    check("sb_be", {28'd0, gb}, 32'h2);
    check("sb_wdata", gw, 32'hA5A5_A5A5);
    check("sb_stalls", 32'(st), 32'd4);
    check("sb_load_kept", load_data, 32'h0000_BEEF);

    // Misaligned LW 0x6
    do_access(1, 0, 2'b10, 0, 32'h6, 32'h0, 32'h1111_1111, 0, 0, st, m0, rq, ga, gw, gb, we);
    check("mis_flag", {31'd0, m0}, 32'd1);
    check("mis_stalls", 32'(st), 32'd0);
    @(negedge clk);
    clear_inputs();
    #1;
    check("mis_one_cycle", {31'd0, misalign}, 32'd0);
    check("mis_no_req", {31'd0, rq | dmem_req}, 32'd0);
    check("mis_load_kept", load_data, 32'h0000_BEEF);

    // Read and write both set: treated as a word store
    do_access(1, 1, 2'b10, 0, 32'h40, 32'hDEAD_BEEF, 32'h5555_5555, 0, 0, st, m0, rq, ga, gw, gb, we);
    check("rw_we", {31'd0, we}, 32'd1);
    check("rw_wdata", gw, 32'hDEAD_BEEF);
    check("rw_be", {28'd0, gb}, 32'hF);
    check("rw_stalls", 32'(st), 32'd2);
    check("rw_load_kept", load_data, 32'h0000_BEEF);

    // Reset during RESP of a LW
    @(negedge clk);
    clear_inputs();
    mem_read = 1'b1; mem_size = 2'b10; addr = 32'h100;
    #1 check("rr_idle_stall", {31'd0, stall}, 32'd1);
    @(negedge clk);
    dmem_gnt = 1'b1;
    #1 check("rr_req", {31'd0, dmem_req}, 32'd1);
    @(negedge clk);
    dmem_gnt = 1'b0;
    #1 check("rr_resp_stall", {31'd0, stall}, 32'd1);
    reset = 1'b0;
    #1;
    check("rr_req_drop", {31'd0, dmem_req}, 32'd0);
    check("rr_load_clr", load_data, 32'd0);
    clear_inputs();
    #1 check("rr_stall_clr", {31'd0, stall}, 32'd0);
    @(negedge clk);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    #1;
    check("rr_late_rvalid", load_data, 32'd0);
    check("rr_idle_nostall", {31'd0, stall}, 32'd0);
    do_access(1, 0, 2'b10, 0, 32'h200, 32'h0, 32'h1234_5678, 0, 1, st, m0, rq, ga, gw, gb, we);
    check("rr_next_addr", ga, 32'h200);
    check("rr_next_load", load_data, 32'h1234_5678);
    check("rr_next_stalls", 32'(st), 32'd4);

    @(negedge clk);
    clear_inputs();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
